cdc_wr_stage: RTL and testbench

Write-domain elastic buffer that sits directly upstream of the 1-deep/2-register FIFO synchronizer. It accepts a valid/ready byte stream from write-domain logic at full rate and absorbs the multi-cycle round trip of the synchronizer's `wrdy`. It presents words to the synchronizer as `wdata`/`wput`, holding each word until `wrdy` accepts it. The block is single-clock and contains no CDC logic of its own.

---
 rtl/cdc_pkg.sv | 9 +
 rtl/cdc_wr_mem.sv | 28 ++
 rtl/cdc_wr_stage.sv | 108 ++++++++++
 tb/tb_cdc_wr_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// cdc_pkg: shared payload type and default sizing
// for the write-side CDC staging buffer.
package cdc_pkg;

    typedef logic [7:0] byte_t;

    localparam int CDC_WSTAGE_DEPTH = 4;

endpackage

// File: rtl/cdc_wr_mem.sv
// cdc_wr_mem: DEPTH x dat_t flop array, one write port
// and a combinational read port. Contents are not reset.
module cdc_wr_mem
    import cdc_pkg::*;
#(
    parameter type dat_t = byte_t,
    parameter int  DEPTH = CDC_WSTAGE_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          wclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  dat_t          d,
    input  logic [AW-1:0] raddr,
    output dat_t          q
);

    dat_t mem_q [DEPTH];

    always_ff @(posedge wclk) begin
        if (we) begin
            mem_q[waddr] <= d;
        end
    end

    assign q = mem_q[raddr];

endmodule

// File: rtl/cdc_wr_stage.sv
// cdc_wr_stage: write-domain elastic buffer feeding the
// FIFO synchronizer; holds each head word until wrdy takes it.
module cdc_wr_stage
    import cdc_pkg::*;
#(
    parameter type dat_t = byte_t,
    parameter int  DEPTH = CDC_WSTAGE_DEPTH
) (
    input  logic                   wclk,
    input  logic                   wrst_n,
    input  dat_t                   s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output dat_t                   wdata,
    output logic                   wput,
    input  logic                   wrdy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
    output logic                   ovf
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            PW       = AW + 1;
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic          stall_q, stall_d;
    dat_t          prev_q, prev_d;

    logic          push;
    logic          pop;
    logic          stall;
    logic [PW-1:0] lvl;

    // Flags come from registered pointers only; wrdy never reaches s_ready.
    assign lvl     = wr_ptr_q - rd_ptr_q;
    assign level   = lvl;
    assign full    = (lvl == FULL_LVL);
    assign empty   = (lvl == '0);
    assign s_ready = ~full;
    assign wput    = ~empty;
    assign ovf     = ovf_q;

    assign push  = s_valid & s_ready;
    assign pop   = wput & wrdy;
    assign stall = s_valid & ~s_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        stall_d  = stall;
        prev_d   = s_data;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        // A word held across consecutive stalled cycles must not change.
        if (stall && stall_q && (s_data != prev_q)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            stall_q  <= 1'b0;
            prev_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            stall_q  <= stall_d;
            prev_q   <= prev_d;
        end
    end

    cdc_wr_mem #(
        .dat_t (dat_t),
        .DEPTH (DEPTH)
    ) u_mem (
        .wclk  (wclk),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .d     (s_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .q     (wdata)
    );

    a_hold : assert property (
        @(posedge wclk) disable iff (!wrst_n)
        (wput && !wrdy) |=> (wput && $stable(wdata))
    );

    a_level : assert property (
        @(posedge wclk) disable iff (!wrst_n)
        (lvl <= FULL_LVL)
    );

endmodule

// File: tb/tb_cdc_wr_stage.sv
// tb_cdc_wr_stage: table-driven fill/drain/concurrency vectors
// plus hand sequences for wrap-around, overflow and reset.
module tb_cdc_wr_stage;

    logic       wclk;
    logic       wrst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] wdata;
    logic       wput;
    logic       wrdy;
    logic [2:0] level;
    logic       empty;
    logic       full;
    logic       ovf;

    int n_chk  = 0;
    int n_pass = 0;

    cdc_wr_stage dut (
        .wclk    (wclk),
        .wrst_n  (wrst_n),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .wdata   (wdata),
        .wput    (wput),
        .wrdy    (wrdy),
        .level   (level),
        .empty   (empty),
        .full    (full),
        .ovf     (ovf)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rdy;
        logic [2:0] lvl;
        logic       emp;
        logic       ful;
        logic       srdy;
        logic       wp;
        logic       ov;
        logic [7:0] wd;
        logic       wchk;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [7:0] d,
                       input logic rdy, input logic [2:0] lvl,
                       input logic [7:0] wd, input logic wchk);
        vec_t e;
        e.v    = v;
        e.d    = d;
        e.rdy  = rdy;
        e.lvl  = lvl;
        e.emp  = (lvl == 3'd0);
        e.ful  = (lvl == 3'd4);
        e.srdy = (lvl != 3'd4);
        e.wp   = (lvl != 3'd0);
        e.ov   = 1'b0;
        e.wd   = wd;
        e.wchk = wchk;
        tbl.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        s_valid = 1'b1;
        s_data  = d;
        step();
        s_valid = 1'b0;
    endtask

    logic [7:0] sb[$];
    int         sent;
    int         got;
    int         cyc;
    logic       hold;
    logic [7:0] hold_d;
    logic       pend;

    initial begin
        wrst_n  = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        wrdy    = 1'b0;
        step();
        step();
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_wput", 32'(wput), 0);
        chk("rst_ovf", 32'(ovf), 0);
        wrst_n = 1'b1;
        step();

        // fill, stalled fifth word, drain
        add(1, 8'h11, 0, 1, 8'h11, 1);
        add(1, 8'h22, 0, 2, 8'h11, 1);
        add(1, 8'h33, 0, 3, 8'h11, 1);
        add(1, 8'h44, 0, 4, 8'h11, 1);
        add(1, 8'h44, 0, 4, 8'h11, 1);
        add(0, 8'h00, 1, 3, 8'h22, 1);
        add(0, 8'h00, 1, 2, 8'h33, 1);
        add(0, 8'h00, 1, 1, 8'h44, 1);
        add(0, 8'h00, 1, 0, 8'h00, 0);
        // push/pop together at level 2
        add(1, 8'hA0, 0, 1, 8'hA0, 1);
        add(1, 8'hA1, 0, 2, 8'hA0, 1);
        add(1, 8'hA2, 1, 2, 8'hA1, 1);
        add(1, 8'hA3, 1, 2, 8'hA2, 1);
        add(1, 8'hA4, 1, 2, 8'hA3, 1);
        add(1, 8'hA5, 1, 2, 8'hA4, 1);
        add(1, 8'hA6, 1, 2, 8'hA5, 1);
        add(1, 8'hA7, 1, 2, 8'hA6, 1);
        // push/pop attempt at full: only the pop happens
        add(1, 8'hA8, 0, 3, 8'hA6, 1);
        add(1, 8'hA9, 0, 4, 8'hA6, 1);
        add(1, 8'hA9, 1, 3, 8'hA7, 1);
        add(0, 8'h00, 1, 2, 8'hA8, 1);
        add(0, 8'h00, 1, 1, 8'hA9, 1);
        add(0, 8'h00, 1, 0, 8'h00, 0);

        foreach (tbl[i]) begin
            s_valid = tbl[i].v;
            s_data  = tbl[i].d;
            wrdy    = tbl[i].rdy;
            step();
            chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].ful));
            chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].srdy));
            chk($sformatf("v%0d_wput", i), 32'(wput), 32'(tbl[i].wp));
            chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(tbl[i].ov));
            if (tbl[i].wchk) begin
                chk($sformatf("v%0d_wdata", i), 32'(wdata), 32'(tbl[i].wd));
            end
        end
        s_valid = 1'b0;
        wrdy    = 1'b0;
        step();

        // wrap-around stream with random wrdy
        sent = 0;
        got  = 0;
        cyc  = 0;
        hold = 1'b0;
        pend = 1'b0;
        while (got < 20 && cyc < 600) begin
            if (!pend) begin
                s_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
            end
            s_data = 8'(sent);
            wrdy   = 1'($urandom_range(0, 1));
            #1;
            if (hold) begin
                chk("stable_wput", 32'(wput), 1);
                chk("stable_wdata", 32'(wdata), 32'(hold_d));
            end
            pend = s_valid && !s_ready;
            if (s_valid && s_ready) begin
                sb.push_back(s_data);
                sent++;
            end
            if (wput && wrdy) begin
                if (sb.size() == 0) begin
                    chk("wrap_extra_word", 32'(wdata), 32'hFFFF_FFFF);
                end else begin
                    chk($sformatf("wrap_word%0d", got), 32'(wdata),
                        32'(sb.pop_front()));
                end
                got++;
            end
            hold   = wput && !wrdy;
            hold_d = wdata;
            step();
            cyc++;
        end
        s_valid = 1'b0;
        wrdy    = 1'b0;
        chk("wrap_received", 32'(got), 20);
        chk("wrap_sent", 32'(sent), 20);
        chk("wrap_empty", 32'(empty), 1);
        chk("wrap_ovf", 32'(ovf), 0);

        // overflow flag
        push_word(8'h51);
        push_word(8'h52);
        push_word(8'h53);
        push_word(8'h55);
        chk("ovf_full", 32'(full), 1);
        s_valid = 1'b1;
        s_data  = 8'h55;
        step();
        chk("ovf_held_data", 32'(ovf), 0);
        s_data = 8'h66;
        step();
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_level", 32'(level), 4);
        s_valid = 1'b0;
        wrdy    = 1'b1;
        step();
        chk("ovf_drain_w0", 32'(wdata), 32'h52);
        step();
        step();
        step();
        chk("ovf_drained", 32'(empty), 1);
        chk("ovf_sticky", 32'(ovf), 1);
        wrdy = 1'b0;

        // asynchronous reset with level 3
        push_word(8'hC1);
        push_word(8'hC2);
        push_word(8'hC3);
        chk("mid_level3", 32'(level), 3);
        #2;
        wrst_n = 1'b0;
        #1;
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_wput", 32'(wput), 0);
        chk("mid_rst_s_ready", 32'(s_ready), 1);
        chk("mid_rst_ovf", 32'(ovf), 0);
        step();
        wrst_n = 1'b1;
        step();
        chk("post_rst_level", 32'(level), 0);
        push_word(8'hA5);
        chk("post_rst_wput", 32'(wput), 1);
        chk("post_rst_wdata", 32'(wdata), 32'hA5);
        chk("post_rst_level1", 32'(level), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
